// File: rtl/shifter_pkg.sv
// Shared constants and encodings for the datapath barrel shifter.
package shifter_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_SIGN = 1'b1;

endpackage

// File: rtl/shifter_unit_shift_stage.sv
// One level of the logarithmic barrel: optional right shift by a fixed distance.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int DIST    = 1
) (
  input  logic [WIDTH_P-1:0] i_data,
  input  logic               i_en,
  input  logic               i_fill,
  output logic [WIDTH_P-1:0] o_data
);

  assign o_data = i_en ? {{DIST{i_fill}}, i_data[WIDTH_P-1:DIST]} : i_data;

endmodule

// File: rtl/shifter_unit.sv
// 32-bit registered barrel shifter; left shifts reuse the right-shift core
// by bit-reversing the operand on the way in and the result on the way out.
module shifter_unit
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int SHW   = shifter_pkg::SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic             direction,
  input  logic             signex,
  output logic [WIDTH-1:0] out
);

  logic             w_is_right;
  logic             w_fill;
  logic [WIDTH-1:0] w_rev_in;
  logic [WIDTH-1:0] w_rev_out;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_stage [SHW+1];
  logic [WIDTH-1:0] r_out;

  assign w_is_right = (direction == DIR_RIGHT);

  // Sign fill only ever applies to arithmetic right shifts; left shifts
  // must shift zeros into the (reversed) top bits.
  assign w_fill = (w_is_right && (signex == FILL_SIGN)) ? in[WIDTH-1] : FILL_ZERO;

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign w_rev_in[g]  = in[WIDTH-1-g];
    assign w_rev_out[g] = w_stage[SHW][WIDTH-1-g];
  end

  assign w_stage[0] = w_is_right ? in : w_rev_in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH_P (WIDTH),
      .DIST    (1 << k)
    ) u_stage (
      .i_data (w_stage[k]),
      .i_en   (shift[k]),
      .i_fill (w_fill),
      .o_data (w_stage[k+1])
    );
  end

  assign w_result = w_is_right ? w_stage[SHW] : w_rev_out;

  // NOTE: registered state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) r_out <= '0;
    else       r_out <= w_result;
  end

  assign out = r_out;

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: expectations are queued when inputs are
// driven and compared one clock later when the registered result appears.
module tb_shifter_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in = 32'h0;
  logic [4:0]  shift = 5'd0;
  logic        direction = 1'b0;
  logic        signex = 1'b0;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  shifter_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .shift     (shift),
    .direction (direction),
    .signex    (signex),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] sh,
                                            input logic dir, input logic sx);
    logic signed [31:0] sa;
    sa = a;
    if (!dir)    return a << sh;
    else if (sx) return sa >>> sh;
    else         return a >> sh;
  endfunction

  // Score the result of the previous cycle's inputs.
  task automatic score();
    logic [31:0] e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, out, e);
    end
  endtask

  // One cycle: compare the output of the last edge, then drive new inputs.
  task automatic step(input logic rst, input logic [31:0] a, input logic [4:0] sh,
                      input logic dir, input logic sx, input logic [31:0] exp,
                      input string tag);
    @(posedge clk);
    #1;
    score();
    reset = rst; in = a; shift = sh; direction = dir; signex = sx;
    exp_q.push_back(rst ? 32'h0 : exp);
    tag_q.push_back(tag);
  endtask

  task automatic step_model(input logic rst, input logic [31:0] a, input logic [4:0] sh,
                            input logic dir, input logic sx, input string tag);
    step(rst, a, sh, dir, sx, ref_model(a, sh, dir, sx), tag);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] zvals [4];

    step(1'b1, 32'hFFFF_FFFD, 5'd1, 1'b1, 1'b1, 32'h0, "reset_cyc1");
    step(1'b1, 32'hFFFF_FFFD, 5'd1, 1'b1, 1'b1, 32'h0, "reset_cyc2");
    step(1'b0, 32'hFFFF_FFFD, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFFE, "post_reset_sra1");
    step(1'b0, 32'hFFFF_FFFD, 5'd1, 1'b1, 1'b0, 32'h7FFF_FFFE, "srl1");
    step(1'b0, 32'hFFFF_FFFD, 5'd1, 1'b0, 1'b0, 32'hFFFF_FFFA, "sll1");

    zvals[0] = 32'hDEAD_BEEF; zvals[1] = 32'h8000_0001;
    zvals[2] = 32'h1234_5678; zvals[3] = 32'hF0F0_0F0F;
    for (int m = 0; m < 4; m++)
      step(1'b0, zvals[m], 5'd0, m[1], m[0], zvals[m], "shift0");

    step(1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, "sra31");
    step(1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, "srl31");
    step(1'b0, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, "sll31");
    step(1'b0, 32'h7FFF_FFFF, 5'd4,  1'b1, 1'b1, 32'h07FF_FFFF, "sra4_pos");
    step(1'b0, 32'h0000_000F, 5'd4,  1'b0, 1'b1, 32'h0000_00F0, "sll4_signex");

    // Back-to-back with a reset pulse in the fourth cycle.
    for (int c = 0; c < 8; c++) begin
      a = 32'hA5A5_0000 | 32'(c * 32'h1111);
      step_model(c == 3, a ^ 32'h8000_0000, 5'(c * 3 + 1), c[0], c[1], "b2b");
    end

    for (int n = 0; n < 10000; n++)
      step_model(1'b0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "random");

    @(posedge clk);
    #1;
    score();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
